// File: rtl/sram_fifo_ctrl.sv
// sram_fifo_ctrl: FIFO controller over a single-port SRAM with a registered pop stage.
// Ports: clk, rst_n (async active-low); push_valid/push_data/push_ready (write side);
// pop_valid/pop_data/pop_ready (read side, pop_data registered); level (words held in SRAM);
// sram_addr/sram_din/sram_wr/sram_rd/sram_cs/sram_dout (SRAM port, combinational read).
// Option: define SRAM_FIFO_WATERMARK_EN to add almost_full (level >= AF_THRESH).
module sram_fifo_ctrl #(
    parameter int DW        = 8,
    parameter int AW        = 8,
    parameter int AF_THRESH = 252
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_valid,
    input  logic [DW-1:0] push_data,
    output logic          push_ready,
    output logic          pop_valid,
    output logic [DW-1:0] pop_data,
    input  logic          pop_ready,
    output logic [AW:0]   level,
`ifdef SRAM_FIFO_WATERMARK_EN
    output logic          almost_full,
`endif
    output logic [AW-1:0] sram_addr,
    output logic [DW-1:0] sram_din,
    output logic          sram_wr,
    output logic          sram_rd,
    output logic          sram_cs,
    input  logic [DW-1:0] sram_dout
);
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          rd_sel, wr_sel;
    // Reads win the single SRAM port so the pop register never starves.
    // level is cleared by reset, so rd_sel is already 0 while rst_n is low.
    always_comb begin
        rd_sel     = (level != '0) && (!pop_valid || pop_ready);
        push_ready = rst_n && !rd_sel && !level[AW];
        wr_sel     = push_ready && push_valid;
        sram_cs    = rd_sel || wr_sel;
        sram_rd    = rd_sel;
        sram_wr    = wr_sel;
        sram_addr  = rd_sel ? rd_ptr : wr_sel ? wr_ptr : '0;
        sram_din   = wr_sel ? push_data : '0;
    end
`ifdef SRAM_FIFO_WATERMARK_EN
    assign almost_full = level >= (AW+1)'(AF_THRESH);
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            pop_valid <= 1'b0;
            pop_data  <= '0;
        end else begin
            if (rd_sel) begin
                pop_data  <= sram_dout;
                pop_valid <= 1'b1;
                rd_ptr    <= rd_ptr + 1'b1;
            end else if (pop_valid && pop_ready) begin
                pop_valid <= 1'b0;
            end
            if (wr_sel) wr_ptr <= wr_ptr + 1'b1;
            level <= level + (AW+1)'(wr_sel) - (AW+1)'(rd_sel);
        end
    end
endmodule
